// File: rtl/rf_pkg.sv
// Shared types for the register-file write-back arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rf_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // One pending register-file write: destination register and data.
    typedef struct packed {
        logic [REG_W-1:0]  rw;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO of write-back requests for the long-latency port.
// Latency: an entry pushed at edge N is visible at the head after edge N (no bypass).
// Backpressure: full_o blocks pushes; push/pop are ignored when full/empty.
//
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   push_i, push_dat_i    enqueue request and payload
//   pop_i                 dequeue the current head
//   head_o                current head entry (valid when !empty_o)
//   full_o, empty_o       occupancy flags
//   count_o               number of valid entries
module rf_wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           push_i,
    input  wb_req_t        push_dat_i,
    input  logic           pop_i,
    output wb_req_t        head_o,
    output logic           full_o,
    output logic           empty_o,
    output logic [PTR_W:0] count_o
);

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    wb_req_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i  & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers wrap naturally because DEPTH is a power of two.
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
        else if (!do_push && do_pop) count_d = count_q - CNT_ONE;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge Clk) begin
        if (do_push && !Reset) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between write-back (A) and long-latency units (B).
// Latency: A writes in the same cycle; B entries commit no earlier than the cycle after acceptance.
// Backpressure: A never stalls; B uses valid/ready into a FIFO, stall_req asks for a bubble on starvation.
//
// Ports:
//   Clk, Reset                  clock, synchronous active-high reset
//   a_wen, a_rw, a_data         port-A write (priority, always accepted)
//   b_valid, b_ready, b_rw, b_data  port-B write handshake
//   iss_valid, iss_rw           long-latency issue: marks iss_rw pending
//   chk_ra, chk_rb, chk_rw      decode registers checked against the scoreboard
//   hazard                      any nonzero chk_* register pending (combinational)
//   stall_req                   registered write-back bubble request
//   WrEn, Rw, busW              register-file write port
//   b_count                     FIFO occupancy (debug)
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int PTR_W      = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              a_wen,
    input  logic [REG_W-1:0]  a_rw,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [REG_W-1:0]  b_rw,
    input  logic [DATA_W-1:0] b_data,
    input  logic              iss_valid,
    input  logic [REG_W-1:0]  iss_rw,
    input  logic [REG_W-1:0]  chk_ra,
    input  logic [REG_W-1:0]  chk_rb,
    input  logic [REG_W-1:0]  chk_rw,
    output logic              hazard,
    output logic              stall_req,
    output logic              WrEn,
    output logic [REG_W-1:0]  Rw,
    output logic [DATA_W-1:0] busW,
    output logic [PTR_W:0]    b_count
);

    localparam logic [7:0] STARVE_LIM  = 8'(STARVE_MAX);
    localparam logic [7:0] STARVE_TRIP = 8'(STARVE_MAX - 1);

    wb_req_t     head;
    wb_req_t     b_req;
    logic        fifo_full, fifo_empty;
    logic        b_push, b_pop;

    logic [31:0] pend_q, pend_d;
    logic [7:0]  starve_q, starve_d;
    logic        stall_q, stall_d;

    assign b_req.rw   = b_rw;
    assign b_req.data = b_data;

    // A full FIFO refuses even if its head pops this cycle: ready does not
    // depend on the pop decision, keeping the path from a_wen to b_ready short.
    assign b_ready = ~fifo_full & ~Reset;
    assign b_push  = b_valid & b_ready;
    assign b_pop   = ~Reset & ~a_wen & ~fifo_empty;

    rf_wb_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .Clk        (Clk),
        .Reset      (Reset),
        .push_i     (b_push),
        .push_dat_i (b_req),
        .pop_i      (b_pop),
        .head_o     (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (b_count)
    );

    // Write-port mux: port A has fixed priority; writes to r0 are dropped.
    always_comb begin
        WrEn = 1'b0;
        Rw   = REG_ZERO;
        busW = '0;
        if (a_wen) begin
            Rw   = a_rw;
            busW = a_data;
            WrEn = (a_rw != REG_ZERO);
        end else if (!fifo_empty) begin
            Rw   = head.rw;
            busW = head.data;
            WrEn = (head.rw != REG_ZERO);
        end
        if (Reset) WrEn = 1'b0;
    end

    // Scoreboard: a committing head clears its bit, a new issue sets it.
    // Set is applied last so it wins on a same-cycle collision.
    always_comb begin
        pend_d = pend_q;
        if (b_pop) pend_d[head.rw] = 1'b0;
        if (iss_valid && iss_rw != REG_ZERO) pend_d[iss_rw] = 1'b1;
        pend_d[0] = 1'b0;
    end

    // Hazard reflects pre-edge state, so a commit this cycle still reports.
    assign hazard = (pend_q[chk_ra] & (chk_ra != REG_ZERO))
                  | (pend_q[chk_rb] & (chk_rb != REG_ZERO))
                  | (pend_q[chk_rw] & (chk_rw != REG_ZERO));

    // Starvation: count cycles the head loses to port A; once it has waited
    // long enough, hold stall_req until the head finally commits.
    always_comb begin
        starve_d = starve_q;
        if (b_pop || fifo_empty)           starve_d = '0;
        else if (starve_q != STARVE_LIM)   starve_d = starve_q + 8'd1;
        stall_d = ((starve_q == STARVE_TRIP) & a_wen & ~fifo_empty)
                | (stall_q & ~b_pop);
    end

    assign stall_req = stall_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pend_q   <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed plan followed by random traffic,
// every cycle compared against a queue-based reference model of the write-back rules.
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        a_wen;
    logic [4:0]  a_rw;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_rw;
    logic [31:0] b_data;
    logic        iss_valid;
    logic [4:0]  iss_rw;
    logic [4:0]  chk_ra, chk_rb, chk_rw;
    logic        hazard, stall_req, WrEn;
    logic [4:0]  Rw;
    logic [31:0] busW;
    logic [2:0]  b_count;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    wb_req_t     m_q[$];
    logic [31:0] m_pend;
    int          m_starve;
    logic        m_stall;

    always #5 Clk = ~Clk;

    rf_wb_arbiter #(.DEPTH(DEPTH), .PTR_W(2), .STARVE_MAX(STARVE_MAX)) dut (
        .Clk(Clk), .Reset(Reset),
        .a_wen(a_wen), .a_rw(a_rw), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rw(b_rw), .b_data(b_data),
        .iss_valid(iss_valid), .iss_rw(iss_rw),
        .chk_ra(chk_ra), .chk_rb(chk_rb), .chk_rw(chk_rw),
        .hazard(hazard), .stall_req(stall_req),
        .WrEn(WrEn), .Rw(Rw), .busW(busW), .b_count(b_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle();
        Reset = 1'b0; a_wen = 1'b0; a_rw = '0; a_data = '0;
        b_valid = 1'b0; b_rw = '0; b_data = '0;
        iss_valid = 1'b0; iss_rw = '0;
        chk_ra = '0; chk_rb = '0; chk_rw = '0;
    endtask

    function automatic logic pend_of(input logic [4:0] r);
        return (r != 5'd0) && m_pend[r];
    endfunction

    // Compare all outputs with what the model predicts for the current inputs.
    task automatic compare();
        logic        e_wen;
        logic [4:0]  e_rw;
        logic [31:0] e_dat;
        e_wen = 1'b0; e_rw = '0; e_dat = '0;
        if (a_wen) begin
            e_rw = a_rw; e_dat = a_data; e_wen = (a_rw != 0);
        end else if (m_q.size() > 0) begin
            e_rw = m_q[0].rw; e_dat = m_q[0].data; e_wen = (m_q[0].rw != 0);
        end
        if (Reset) e_wen = 1'b0;
        chk("WrEn", WrEn, e_wen);
        if (!Reset) begin
            chk("Rw", Rw, e_rw);
            chk("busW", busW, e_dat);
        end
        chk("b_ready", b_ready, (m_q.size() < DEPTH) && !Reset);
        chk("hazard", hazard, pend_of(chk_ra) | pend_of(chk_rb) | pend_of(chk_rw));
        chk("stall_req", stall_req, m_stall);
        chk("b_count", b_count, m_q.size());
    endtask

    // Advance the model by one clock edge using the inputs held across it.
    task automatic model_edge();
        bit      nonempty, popped, accepted, new_stall;
        wb_req_t h;
        if (Reset) begin
            m_q.delete(); m_pend = '0; m_starve = 0; m_stall = 1'b0;
        end else begin
            nonempty  = (m_q.size() > 0);
            popped    = !a_wen && nonempty;
            accepted  = b_valid && (m_q.size() < DEPTH);
            new_stall = (m_starve == STARVE_MAX - 1 && a_wen && nonempty) || (m_stall && !popped);
            if (popped || !nonempty)       m_starve = 0;
            else if (m_starve < STARVE_MAX) m_starve++;
            if (popped) begin
                h = m_q.pop_front();
                if (h.rw != 0) m_pend[h.rw] = 1'b0;
            end
            if (iss_valid && iss_rw != 0) m_pend[iss_rw] = 1'b1;
            if (accepted) begin
                h.rw = b_rw; h.data = b_data;
                m_q.push_back(h);
            end
            m_stall = new_stall;
        end
    endtask

    task automatic step();
        #1;
        compare();
        @(posedge Clk);
        model_edge();
        #1;
    endtask

    initial begin
        int r;
        idle();
        Reset = 1'b1;
        m_q.delete(); m_pend = '0; m_starve = 0; m_stall = 1'b0;
        @(posedge Clk); @(posedge Clk); #1;

        // Reset holds WrEn and b_ready low even with a_wen asserted
        a_wen = 1'b1; a_rw = 5'd3; a_data = 32'hdead;
        #1;
        chk("rst_WrEn", WrEn, 1'b0);
        chk("rst_b_ready", b_ready, 1'b0);
        step();

        // Port A passes straight through
        idle();
        a_wen = 1'b1; a_rw = 5'd8; a_data = 32'd5;
        #1;
        chk("a_WrEn", WrEn, 1'b1);
        chk("a_Rw", Rw, 5'd8);
        chk("a_busW", busW, 32'd5);
        chk("a_b_count", b_count, 3'd0);
        chk("a_stall", stall_req, 1'b0);
        step();

        // Issue r9, detect hazard, B result clears it one cycle after commit
        idle(); iss_valid = 1'b1; iss_rw = 5'd9; step();
        idle(); chk_ra = 5'd9;
        #1; chk("haz_r9", hazard, 1'b1);
        b_valid = 1'b1; b_rw = 5'd9; b_data = 32'h1234;
        #1; chk("b_no_bypass", WrEn, 1'b0);
        step();
        b_valid = 1'b0;
        #1;
        chk("b_WrEn", WrEn, 1'b1);
        chk("b_Rw", Rw, 5'd9);
        chk("b_busW", busW, 32'h1234);
        chk("haz_during_commit", hazard, 1'b1);
        step();
        #1; chk("haz_cleared", hazard, 1'b0);

        // Fill FIFO behind port A, then drain in order
        idle(); a_wen = 1'b1; a_rw = 5'd3; a_data = 32'h33;
        for (int i = 0; i < DEPTH; i++) begin
            b_valid = 1'b1; b_rw = 5'(11 + i); b_data = 32'hb000 + i;
            step();
        end
        b_rw = 5'd20; b_data = 32'hffff;
        #1;
        chk("full_ready", b_ready, 1'b0);
        chk("full_count", b_count, 3'd4);
        step();
        b_valid = 1'b0; a_wen = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            #1; chk("drain_order", Rw, 5'(11 + i));
            step();
        end

        // Starvation: one entry held off by port A for STARVE_MAX cycles
        idle(); a_wen = 1'b1; a_rw = 5'd4;
        b_valid = 1'b1; b_rw = 5'd15; b_data = 32'h15;
        step();
        b_valid = 1'b0;
        for (int i = 0; i < STARVE_MAX; i++) step();
        #1; chk("stall_set", stall_req, 1'b1);
        a_wen = 1'b0;
        #1; chk("starved_commit", Rw, 5'd15);
        step();
        #1; chk("stall_drop", stall_req, 1'b0);

        // r0 writes are dropped on both ports
        idle(); b_valid = 1'b1; b_rw = 5'd0; b_data = 32'h77; step();
        idle();
        #1; chk("b_r0_WrEn", WrEn, 1'b0);
        step();
        #1; chk("b_r0_popped", b_count, 3'd0);
        a_wen = 1'b1; a_rw = 5'd0; a_data = 32'h99;
        #1; chk("a_r0_WrEn", WrEn, 1'b0);
        step();

        // Same-cycle commit and re-issue of r10: set wins
        idle(); iss_valid = 1'b1; iss_rw = 5'd10; step();
        idle(); a_wen = 1'b1; a_rw = 5'd2; b_valid = 1'b1; b_rw = 5'd10; b_data = 32'ha; step();
        idle(); iss_valid = 1'b1; iss_rw = 5'd10; step();
        idle(); chk_rb = 5'd10;
        #1; chk("set_wins", hazard, 1'b1);
        step();

        // Reset mid-drain with three queued entries
        idle(); a_wen = 1'b1; a_rw = 5'd5; chk_rb = 5'd10;
        for (int i = 0; i < 3; i++) begin
            b_valid = 1'b1; b_rw = 5'(21 + i); b_data = 32'hc0 + i;
            step();
        end
        b_valid = 1'b0; Reset = 1'b1; step();
        Reset = 1'b0; a_wen = 1'b0;
        #1;
        chk("rst_count", b_count, 3'd0);
        chk("rst_hazard", hazard, 1'b0);
        chk("rst_no_bwrite", WrEn, 1'b0);
        step();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            Reset     = ($urandom_range(0, 199) == 0);
            a_wen     = m_stall ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 9) < 6);
            a_rw      = 5'($urandom_range(0, 31));
            a_data    = $urandom;
            b_valid   = ($urandom_range(0, 2) != 0);
            b_rw      = 5'($urandom_range(0, 31));
            b_data    = $urandom;
            r         = $urandom_range(0, 31);
            iss_valid = ($urandom_range(0, 3) == 0) && !m_pend[r];
            iss_rw    = 5'(r);
            chk_ra    = 5'($urandom_range(0, 31));
            chk_rb    = 5'($urandom_range(0, 31));
            chk_rw    = 5'($urandom_range(0, 31));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between two writers.
  - Port A: the main pipeline write-back stage. Fixed priority, never back-pressured.
  - Port B: the long-latency units (multiply/divide, slow loads). valid/ready handshake, buffered in a small FIFO.
- Holds a per-register pending scoreboard so decode can detect RAW/WAW hazards against outstanding port-B results.
- Sits between the write-back stage / long-latency units and the register file write inputs (WrEn, Rw, busW).

Parameters:
- DEPTH, 4, port-B FIFO entries; power of two, 2..16.
- PTR_W, 2, log2(DEPTH).
- STARVE_MAX, 8, cycles a waiting FIFO head tolerates before stall_req asserts; 1..255.

Ports:
- Clk  in  1  system clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- a_wen  in  1  port-A write request; accepted unconditionally.
- a_rw  in  5  port-A destination register.
- a_data  in  32  port-A write data.
- b_valid  in  1  port-B write offered.
- b_ready  out  1  port-B FIFO can accept; transfer when b_valid & b_ready.
- b_rw  in  5  port-B destination register.
- b_data  in  32  port-B write data.
- iss_valid  in  1  long-latency op issued; mark iss_rw pending.
- iss_rw  in  5  destination of the issued op.
- chk_ra  in  5  decode source A to check.
- chk_rb  in  5  decode source B to check.
- chk_rw  in  5  decode destination to check (WAW).
- hazard  out  1  combinational: any nonzero chk_* register is pending.
- stall_req  out  1  registered: asks the pipeline for a write-back bubble.
- WrEn  out  1  register file write enable.
- Rw  out  5  register file write address.
- busW  out  32  register file write data.
- b_count  out  PTR_W+1  FIFO occupancy, for debug.

Behaviour:
- Reset, synchronous:
  - FIFO pointers and count 0; scoreboard all 0; starvation counter 0; stall_req 0.
  - WrEn forced 0 while Reset is high, including a_wen.
  - b_ready 0 while Reset is high.
- Write-port mux, combinational, zero latency:
  - If a_wen: Rw=a_rw, busW=a_data, WrEn=(a_rw!=0).
  - Else if FIFO non-empty: Rw=head.rw, busW=head.data, WrEn=(head.rw!=0); head pops at the clock edge.
  - Else: WrEn=0, Rw=0, busW=0.
- Head with rw=0: still pops and clears nothing; the write is dropped.
- Port-B input:
  - b_ready = (count<DEPTH) & ~Reset.
  - No bypass: an accepted entry is writable no earlier than the next cycle, so minimum B latency is 1.
  - When full, b_ready stays 0 even if a pop happens in the same cycle.
  - Push and pop in the same cycle leave count unchanged.
- Scoreboard, 32 bits, bit 0 hard-wired 0:
  - Set on iss_valid & iss_rw!=0.
  - Cleared when a FIFO head with that rw commits.
  - Set and clear of the same register in one cycle: set wins, bit stays 1.
  - Issuing to an already-pending register is a protocol violation; decode must stall on hazard via chk_rw. The block does not count duplicates.
- hazard = pend[chk_ra] | pend[chk_rb] | pend[chk_rw], with register 0 excluded. Reflects state before the current edge, so a commit this cycle does not clear hazard until the next cycle.
- Starvation control:
  - The counter increments each cycle the FIFO is non-empty and a_wen=1.
  - It resets to 0 on any pop or when the FIFO is empty, and saturates at STARVE_MAX.
  - stall_req <= (counter==STARVE_MAX-1 & a_wen & FIFO non-empty) | (stall_req & no pop this cycle).
  - stall_req drops the cycle after the head commits.
  - The pipeline must hold a_wen=0 while stall_req=1. If a_wen is asserted anyway, port A still wins.
- No port-A-vs-scoreboard interaction: A writes never clear pending bits.

Decomposition:
- Shared package rf_pkg:
  - REG_W=5, DATA_W=32, REG_ZERO=5'd0.
  - Struct/typedef wb_req_t {rw[4:0], data[31:0]}.
- One natural sub-module: rf_wb_fifo, a synchronous FIFO of wb_req_t with push, pop, full, empty and count.
- Scoreboard, mux and starvation logic stay in the top module.

Test Plan:
- Reset, then a_wen=1, a_rw=8, a_data=5 -> same cycle WrEn=1, Rw=8, busW=5; b_count=0; stall_req=0.
- iss_valid with iss_rw=9; next cycle chk_ra=9 -> hazard=1. Push b_rw=9, b_data=0x1234 while a_wen=0 -> write appears the cycle after acceptance; hazard=0 one cycle later.
- Push 4 B entries with a_wen held 1 -> b_ready=0 at count 4. On release of A, heads drain one per cycle in order (FIFO order preserved), no drops.
- Push 1 B entry and hold a_wen=1 -> stall_req=1 after 8 cycles. Then a_wen=0 -> B commits; stall_req=0 the next cycle.
- B entry with b_rw=0 -> WrEn=0 at its slot, FIFO pops, scoreboard unchanged. Also a_rw=0 -> WrEn=0.
- Same cycle: commit of reg 10 and iss_valid with iss_rw=10 -> pend[10]=1 and hazard on chk_rb=10. Assert Reset mid-drain with 3 entries queued -> count=0, hazard=0, WrEn=0, no further B writes.
